csa_word_sequencer: RTL
=======================

# csa_word_sequencer

Multi-cycle controller that performs NBYTES-wide addition and subtraction by sequencing one 8-bit conditionalSumAdder instance byte by byte. Carry is chained through a register, least-significant byte first. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the scheduler that lets the 8-bit CSA datapath serve 16/32/64-bit arithmetic without replicating it.

## Interface
Parameters:
- NBYTES, 4, operand width in bytes (legal 2..8); W = 8*NBYTES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  operand request.
- start_ready  out  1  high only in IDLE.
- a  in  W  operand A; captured on accept.
- b  in  W  operand B; captured on accept.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  1 = A - B (A + ~B + 1); captured on accept.
- done_valid  out  1  result available.
- done_ready  in  1  consumer accepts result.
- sum  out  W  result.
- cout  out  1  final carry-out; for sub, 1 = no borrow.
- ovf  out  1  signed (two's-complement) overflow.
- busy  out  1  high in RUN.

## Operation
- Internal: one conditionalSumAdder (x, y, c0, S, cOut); regs opa, opb (W), carry, idx (3 bits), sum, cout, ovf; FSM IDLE/RUN/DONE.
- Adder inputs: x = opa byte[idx], y = opb byte[idx], c0 = carry.

IDLE:
- start_ready=1.
- On start_valid: opa<=a; opb<=(sub ? ~b : b); carry<=(sub ? 1 : cin); idx<=0; sum<=0; go to RUN.

RUN (one byte per cycle):
- sum byte[idx] <= S; carry <= cOut; idx <= idx+1.
- On idx==NBYTES-1: cout <= cOut; ovf <= (opa[W-1]==opb[W-1]) && (S[7]!=opa[W-1]); go to DONE.

DONE:
- done_valid=1; sum/cout/ovf held stable.
- On done_ready: go to IDLE.
- start_valid is ignored in DONE (start_ready=0). There is no same-cycle turnaround; the next accept is possible one cycle after done_ready.

Width rules:
- W-bit wrap-around; no saturation.
- Carry never leaks between operations: it is reloaded on every accept.

Outputs:
- sum/cout/ovf change only in RUN and hold from RUN exit until the next accept.
- In IDLE they show the last result.

## Timing
- Reset (async, immediate): state=IDLE, start_ready=1, done_valid=0, busy=0, sum=0, cout=0, ovf=0, carry=0, idx=0, opa=opb=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. The result is discarded and no done_valid pulse is emitted.
- Accept at rising edge k (start_valid & start_ready).
- busy=1 for cycles k..k+NBYTES-1.
- done_valid rises after edge k+NBYTES (latency NBYTES cycles, accept to result).
- done_valid holds until the edge where done_ready=1. It falls after that edge, and start_ready rises in the same cycle.
- Throughput: one operation per NBYTES+2 cycles with done_ready tied high.
- done_ready high while not in DONE has no effect.
- start_valid high while not in IDLE has no effect; the request is not queued.
- Operand changes after accept have no effect on the in-flight operation.

## Test plan
- Add, NBYTES=4: a=0x0000000C, b=0x00000005, cin=0 -> sum=0x00000011, cout=0, ovf=0, done_valid 4 cycles after accept. Repeat with cin=1 -> sum=0x00000012.
- Carry chain: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0. With cin=1 -> sum=0x00000001, cout=1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Subtract: a=12, b=5, sub=1 -> sum=0x00000007, cout=1, ovf=0. Then a=5, b=12, sub=1 -> sum=0xFFFFFFF9, cout=0, ovf=0; confirm cin is ignored.
- Backpressure: hold done_ready=0 for 10 cycles with start_valid=1 and changing a/b. Required: sum stable, start_ready=0, no second accept. Release done_ready -> IDLE next cycle, the new request is accepted, and its result is correct.
- Reset mid-operation: assert rst after 2 RUN cycles of 0xFFFFFFFF+1. Required: immediate IDLE, done_valid=0, sum=0. After release, 0x00000100+0x000000FF gives 0x000001FF with cout=0 (no stale carry).

Source files
------------

// File: rtl/csa_word_sequencer.sv
// Multi-byte add/subtract sequencer: one 8-bit conditional-sum adder is reused
// byte by byte, least-significant first, with the carry chained through a register.

module conditional_sum_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c0,
    output logic [7:0] s,
    output logic       cout
);
    // [block][carry-in] pre-computed 2-bit sums and carries
    logic [3:0][1:0][1:0] blk_s;
    logic [3:0][1:0]      blk_c;
    logic [1:0][1:0][3:0] nib_s;
    logic [1:0][1:0]      nib_c;

    always_comb begin
        blk_s = '0;
        blk_c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                {blk_c[i][k], blk_s[i][k]} = 3'(x[2*i +: 2]) + 3'(y[2*i +: 2]) + 3'(k);
            end
        end
    end

    // Merge 2-bit blocks into nibbles, each still for both carry-in values
    always_comb begin
        nib_s = '0;
        nib_c = '0;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 2; k++) begin
                nib_s[j][k] = {blk_c[2*j][k] ? blk_s[2*j+1][1] : blk_s[2*j+1][0],
                               blk_s[2*j][k]};
                nib_c[j][k] = blk_c[2*j][k] ? blk_c[2*j+1][1] : blk_c[2*j+1][0];
            end
        end
    end

    always_comb begin
        s    = {nib_c[0][c0] ? nib_s[1][1] : nib_s[1][0], nib_s[0][c0]};
        cout = nib_c[0][c0] ? nib_c[1][1] : nib_c[1][0];
    end
endmodule

module csa_word_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int unsigned W = 8 * NBYTES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           carry_q, carry_d;
    logic [2:0]     idx_q, idx_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [7:0]     add_x, add_y, add_s;
    logic           add_cout;

    assign add_x = opa_q[{idx_q, 3'b000} +: 8];
    assign add_y = opb_q[{idx_q, 3'b000} +: 8];

    conditional_sum_adder u_csa (
        .x    (add_x),
        .y    (add_y),
        .c0   (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Subtraction is folded into the accept: B is inverted and the carry forced to 1
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{idx_q, 3'b000} +: 8] = add_s;
                carry_d = add_cout;
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'(NBYTES - 1)) begin
                    cout_d  = add_cout;
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (add_s[7] != opa_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == IDLE);
        busy        = (state_q == RUN);
        done_valid  = (state_q == DONE);
        sum         = sum_q;
        cout        = cout_q;
        ovf         = ovf_q;
    end
endmodule
